// File: rtl/fb_sched_pkg.sv
// Shared types for the framebuffer port scheduler: FSM states and the
// read-return tag carried alongside each outstanding memory read.
package fb_sched_pkg;

    localparam int TAG_IDX_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_e;

    typedef struct packed {
        logic                 valid;
        logic                 bank;
        logic [TAG_IDX_W-1:0] idx;
    } rd_tag_t;

endpackage

// File: rtl/read_tag_pipe.sv
// Delays each read tag by the memory latency so the line-buffer write
// lines up with the returning data.
module read_tag_pipe
    import fb_sched_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int IDX_W = 8
) (
    input  logic             clk_pixel_in,
    input  logic             rst_in,
    input  rd_tag_t          tag_in,
    output logic             lb_we_out,
    output logic [IDX_W:0]   lb_addr_out
);

    rd_tag_t pipe_q [DEPTH];
    logic    unused_idx_hi;

    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            for (int k = 0; k < DEPTH; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_in;
            for (int k = 1; k < DEPTH; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    assign lb_we_out     = pipe_q[DEPTH-1].valid;
    assign lb_addr_out   = {pipe_q[DEPTH-1].bank,
                            pipe_q[DEPTH-1].idx[IDX_W-1:0]};
    assign unused_idx_hi = |pipe_q[DEPTH-1].idx[TAG_IDX_W-1:IDX_W];

endmodule

// File: rtl/framebuffer_port_sched.sv
// Shares the single framebuffer port between hblank line prefetch and
// the pixel writer; prefetch bursts always win the port.
module framebuffer_port_sched
    import fb_sched_pkg::*;
#(
    parameter int ACTIVE_H_PIXELS = 1280,
    parameter int TOTAL_PIXELS    = 1650,
    parameter int ACTIVE_LINES    = 720,
    parameter int TOTAL_LINES     = 750,
    parameter int LINE_WORDS      = 160,
    parameter int DATA_WIDTH      = 64,
    parameter int ADDR_WIDTH      = 17,
    parameter int MEM_LATENCY     = 2
) (
    input  logic                             clk_pixel_in,
    input  logic                             rst_in,
    input  logic [$clog2(TOTAL_PIXELS)-1:0]  hcount_in,
    input  logic [$clog2(TOTAL_LINES)-1:0]   vcount_in,
    input  logic                             wr_valid_in,
    input  logic [ADDR_WIDTH-1:0]            wr_addr_in,
    input  logic [DATA_WIDTH-1:0]            wr_data_in,
    output logic                             wr_ready_out,
    output logic                             mem_en_out,
    output logic                             mem_we_out,
    output logic [ADDR_WIDTH-1:0]            mem_addr_out,
    output logic [DATA_WIDTH-1:0]            mem_wdata_out,
    input  logic [DATA_WIDTH-1:0]            mem_rdata_in,
    output logic                             lb_we_out,
    output logic [$clog2(LINE_WORDS):0]      lb_addr_out,
    output logic [DATA_WIDTH-1:0]            lb_data_out,
    output logic                             busy_out,
    output logic                             underrun_out
);

    localparam int HW = $clog2(TOTAL_PIXELS);
    localparam int VW = $clog2(TOTAL_LINES);
    localparam int IW = $clog2(LINE_WORDS);
    localparam int DW = $clog2(MEM_LATENCY + 1);
    localparam int AW = ADDR_WIDTH;

    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q;
    logic [DW-1:0]       dcnt_q;
    logic [AW-1:0]       base_q, base_nx;
    logic                bank_q, bank_nx;
    logic                trig, trig_wrap, start;
    logic                last_word, fetch_more, wr_fire;
    logic                en_d, we_d;
    logic [AW-1:0]       addr_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    rd_tag_t             tag_d, tag_q;

    assign trig_wrap  = vcount_in == VW'(TOTAL_LINES - 1);
    assign trig       = (hcount_in == HW'(ACTIVE_H_PIXELS))
                     && (trig_wrap || vcount_in < VW'(ACTIVE_LINES - 1));
    assign start      = trig && state_q == IDLE;
    assign last_word  = idx_q == IW'(LINE_WORDS - 1);
    assign fetch_more = state_q == FETCH && !last_word;

    assign wr_ready_out = !rst_in && !start && !fetch_more;
    assign wr_fire      = wr_valid_in && wr_ready_out;

    // Running base: a line later than the last fetched one, or frame top.
    assign base_nx  = trig_wrap ? '0 : base_q + AW'(LINE_WORDS);
    assign bank_nx  = !trig_wrap && !vcount_in[0];
    assign busy_out = state_q != IDLE;

    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = FETCH;
            FETCH:   if (last_word) state_d = DRAIN;
            DRAIN:   if (dcnt_q == DW'(MEM_LATENCY - 1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next port operation; the three sources are mutually exclusive.
    always_comb begin
        en_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = mem_addr_out;
        wdata_d = mem_wdata_out;
        tag_d   = '0;
        unique case (1'b1)
            start: begin
                en_d       = 1'b1;
                addr_d     = base_nx;
                tag_d.valid = 1'b1;
                tag_d.bank = bank_nx;
            end
            fetch_more: begin
                en_d       = 1'b1;
                addr_d     = base_q + AW'(idx_q) + AW'(1);
                tag_d.valid = 1'b1;
                tag_d.bank = bank_q;
                tag_d.idx  = TAG_IDX_W'(idx_q + IW'(1));
            end
            wr_fire: begin
                en_d    = 1'b1;
                we_d    = 1'b1;
                addr_d  = wr_addr_in;
                wdata_d = wr_data_in;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_pixel_in or posedge rst_in) begin
        if (rst_in) begin
            idx_q         <= '0;
            dcnt_q        <= '0;
            base_q        <= '0;
            bank_q        <= 1'b0;
            tag_q         <= '0;
            mem_en_out    <= 1'b0;
            mem_we_out    <= 1'b0;
            mem_addr_out  <= '0;
            mem_wdata_out <= '0;
            underrun_out  <= 1'b0;
        end else begin
            mem_en_out    <= en_d;
            mem_we_out    <= we_d;
            mem_addr_out  <= addr_d;
            mem_wdata_out <= wdata_d;
            tag_q         <= tag_d;
            if (start) begin
                base_q <= base_nx;
                bank_q <= bank_nx;
                idx_q  <= '0;
            end else if (fetch_more) begin
                idx_q <= idx_q + IW'(1);
            end
            if (state_q == FETCH) begin
                dcnt_q <= '0;
            end else if (state_q == DRAIN) begin
                dcnt_q <= dcnt_q + DW'(1);
            end
            if (busy_out && (trig || (hcount_in == '0
                    && vcount_in < VW'(ACTIVE_LINES)))) begin
                underrun_out <= 1'b1;
            end
        end
    end

    read_tag_pipe #(
        .DEPTH (MEM_LATENCY),
        .IDX_W (IW)
    ) u_tag_pipe (
        .clk_pixel_in (clk_pixel_in),
        .rst_in       (rst_in),
        .tag_in       (tag_q),
        .lb_we_out    (lb_we_out),
        .lb_addr_out  (lb_addr_out)
    );

    assign lb_data_out = lb_we_out ? mem_rdata_in : '0;

endmodule

// File: tb/tb_framebuffer_port_sched.sv
// Directed bench for framebuffer_port_sched: bursts, writer sharing,
// underrun and reset; a small-line instance walks a whole frame.
module tb_framebuffer_port_sched;

    localparam int AW = 17;
    localparam int DW = 64;
    localparam int LW = 160;
    localparam int HW = 11;
    localparam int VW = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [HW-1:0] hc;
    logic [VW-1:0] vc;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready, mem_en, mem_we, lb_we, busy, urun;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, rdata, lb_data;
    logic [8:0]    lb_addr;
    logic [AW-1:0] rd_a0, rd_a1;

    logic [HW-1:0] s_hc;
    logic [VW-1:0] s_vc;
    logic          s_wv;
    logic [AW-1:0] s_wa;
    logic [DW-1:0] s_wd, s_rd;
    logic          s_rdy, s_en, s_we, s_lb_we, s_busy, s_urun;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_lb_data;
    logic [3:0]    s_lb_addr;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [DW-1:0] mdat(input logic [AW-1:0] a);
        return {15'h2B3C, a, 32'hDEAD_BEEF};
    endfunction

    // Memory returns data two cycles after the address is presented.
    always @(posedge clk) begin
        rd_a0 <= mem_addr;
        rd_a1 <= rd_a0;
    end
    assign rdata = mdat(rd_a1);

    framebuffer_port_sched u_dut (
        .clk_pixel_in  (clk),
        .rst_in        (rst),
        .hcount_in     (hc),
        .vcount_in     (vc),
        .wr_valid_in   (wr_valid),
        .wr_addr_in    (wr_addr),
        .wr_data_in    (wr_data),
        .wr_ready_out  (wr_ready),
        .mem_en_out    (mem_en),
        .mem_we_out    (mem_we),
        .mem_addr_out  (mem_addr),
        .mem_wdata_out (mem_wdata),
        .mem_rdata_in  (rdata),
        .lb_we_out     (lb_we),
        .lb_addr_out   (lb_addr),
        .lb_data_out   (lb_data),
        .busy_out      (busy),
        .underrun_out  (urun)
    );

    framebuffer_port_sched #(.LINE_WORDS(8)) u_sml (
        .clk_pixel_in  (clk),
        .rst_in        (rst),
        .hcount_in     (s_hc),
        .vcount_in     (s_vc),
        .wr_valid_in   (s_wv),
        .wr_addr_in    (s_wa),
        .wr_data_in    (s_wd),
        .wr_ready_out  (s_rdy),
        .mem_en_out    (s_en),
        .mem_we_out    (s_we),
        .mem_addr_out  (s_addr),
        .mem_wdata_out (s_wdata),
        .mem_rdata_in  (s_rd),
        .lb_we_out     (s_lb_we),
        .lb_addr_out   (s_lb_addr),
        .lb_data_out   (s_lb_data),
        .busy_out      (s_busy),
        .underrun_out  (s_urun)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Call at the start of the trigger cycle T with vc already set.
    task automatic watch_burst(input string tag, input int base_e,
                               input logic bank_e, input bit wr_mode,
                               input int retrig);
        int rd_ok = 0;
        int lb_ok = 0;
        int stray = 0;
        int busy_bad = 0;
        int rdy_bad = 0;
        int wr_seen = 0;
        for (int k = 0; k <= 165; k++) begin
            hc = (k == 0 || k == retrig) ? 11'd1280 : 11'd1281;
            if (wr_mode) begin
                wr_valid = (k <= 160);
                wr_addr  = 17'h1ABCD;
                wr_data  = 64'h0123_4567_89AB_CDEF;
            end
            @(negedge clk);
            if (k >= 1 && k <= 160) begin
                if (mem_en && !mem_we && mem_addr == AW'(base_e + k - 1))
                    rd_ok++;
            end else if (wr_mode && k == 161) begin
                if (mem_en && mem_we && mem_addr == 17'h1ABCD
                        && mem_wdata == 64'h0123_4567_89AB_CDEF)
                    wr_seen++;
            end else if (mem_en) begin
                stray++;
            end
            if (k >= 3 && k <= 162) begin
                if (lb_we && lb_addr == {bank_e, 8'(k - 3)}
                        && lb_data == mdat(AW'(base_e + k - 3)))
                    lb_ok++;
            end else if (lb_we) begin
                stray++;
            end
            if (busy != (k >= 1 && k <= 162)) busy_bad++;
            if (wr_ready != (k >= 160)) rdy_bad++;
            step();
        end
        wr_valid = 1'b0;
        hc = 11'd100;
        chk({tag, "_reads"}, 64'(rd_ok), 64'(LW));
        chk({tag, "_lbwr"}, 64'(lb_ok), 64'(LW));
        chk({tag, "_stray"}, 64'(stray), 64'd0);
        chk({tag, "_busy"}, 64'(busy_bad), 64'd0);
        chk({tag, "_ready"}, 64'(rdy_bad), 64'd0);
        if (wr_mode) chk({tag, "_wr"}, 64'(wr_seen), 64'd1);
    endtask

    initial begin
        int bad_rdy;
        int bad_wr;
        int rd_n;
        int rd_ok;
        int lb1;
        int stray;
        rst = 1'b1;
        hc = 11'd100;
        vc = 10'd730;
        wr_valid = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        s_hc = 11'd100;
        s_vc = 10'd730;
        s_wv = 1'b0;
        s_wa = '0;
        s_wd = '0;
        s_rd = '0;

        repeat (2) @(negedge clk);
        chk("rst_en", 64'(mem_en), 64'd0);
        chk("rst_ready", 64'(wr_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_urun", 64'(urun), 64'd0);
        chk("rst_lbwe", 64'(lb_we), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_idle", 64'(wr_ready), 64'd1);
        step();

        vc = 10'd749;
        hc = 11'd1279;
        @(negedge clk);
        chk("pre_trig_en", 64'(mem_en), 64'd0);
        step();
        watch_burst("frame0", 0, 1'b0, 1'b0, -1);
        vc = 10'd0;
        watch_burst("line1", 160, 1'b1, 1'b0, -1);

        vc = 10'd730;
        bad_rdy = 0;
        bad_wr = 0;
        for (int j = 0; j <= 6; j++) begin
            wr_valid = (j < 5);
            wr_addr  = AW'(10 + j);
            wr_data  = 64'hCAFE_0000_0000_0000 + 64'(j);
            @(negedge clk);
            if (j < 5 && !wr_ready) bad_rdy++;
            if (j >= 1 && j <= 5) begin
                if (!(mem_en && mem_we && mem_addr == AW'(9 + j)
                      && mem_wdata == 64'hCAFE_0000_0000_0000 + 64'(j - 1)))
                    bad_wr++;
            end
            if (j == 6 && mem_en) bad_wr++;
            step();
        end
        wr_valid = 1'b0;
        chk("idle_wr_ready", 64'(bad_rdy), 64'd0);
        chk("idle_wr_ops", 64'(bad_wr), 64'd0);

        vc = 10'd1;
        watch_burst("wr_cont", 320, 1'b0, 1'b1, -1);

        vc = 10'd2;
        @(negedge clk);
        chk("urun_pre", 64'(urun), 64'd0);
        step();
        watch_burst("urun", 480, 1'b1, 1'b0, 50);
        chk("urun_set", 64'(urun), 64'd1);
        repeat (20) step();
        chk("urun_sticky", 64'(urun), 64'd1);

        vc = 10'd3;
        hc = 11'd1280;
        step();
        hc = 11'd1281;
        repeat (49) step();
        rst = 1'b1;
        #1;
        chk("arst_en", 64'(mem_en), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_urun", 64'(urun), 64'd0);
        chk("arst_lbwe", 64'(lb_we), 64'd0);
        chk("arst_ready", 64'(wr_ready), 64'd0);
        chk("arst_addr", 64'(mem_addr), 64'd0);
        chk("arst_wdata", 64'(mem_wdata), 64'd0);
        chk("arst_lbdata", lb_data, 64'd0);
        step();
        step();
        rst = 1'b0;
        hc = 11'd100;
        stray = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (lb_we || mem_en || busy) stray++;
            step();
        end
        chk("arst_quiet", 64'(stray), 64'd0);
        vc = 10'd3;
        watch_burst("post_rst", 160, 1'b0, 1'b0, -1);

        // Whole frame on the 8-word instance.
        rd_n = 0;
        rd_ok = 0;
        lb1 = 0;
        stray = 0;
        s_vc = 10'd749;
        s_hc = 11'd1280;
        step();
        s_hc = 11'd1281;
        repeat (12) step();
        for (int v = 0; v <= 748; v++) begin
            s_vc = VW'(v);
            for (int k = 0; k < 13; k++) begin
                s_hc = (k == 0) ? 11'd1280 : 11'd1281;
                @(negedge clk);
                if (v == 718 && s_en && !s_we) begin
                    if (s_addr == AW'(5752 + rd_n)) rd_ok++;
                    rd_n++;
                end
                if (v == 718 && s_lb_we && s_lb_addr[3]) lb1++;
                if (v >= 719 && (s_en || s_lb_we)) stray++;
                step();
            end
        end
        chk("l718_reads", 64'(rd_n), 64'd8);
        chk("l718_addr", 64'(rd_ok), 64'd8);
        chk("l718_bank1", 64'(lb1), 64'd8);
        chk("blank_nofetch", 64'(stray), 64'd0);
        chk("sml_urun", 64'(s_urun), 64'd0);
        chk("sml_busy", 64'(s_busy), 64'd0);
        chk("sml_ready", 64'(s_rdy), 64'd1);
        chk("sml_wdata", s_wdata, 64'd0);
        chk("sml_lbdata", s_lb_data, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
